// File: rtl/gpio_periph.sv
// gpio_periph: board-side GPIO endpoint.
// Switches pass through a two-flop synchronizer and a whole-vector debouncer
// before reaching the CPU. The CPU output word is shown in hex on an 8-digit
// multiplexed seven-segment display. The word is latched once per frame, so a
// frame never mixes two values.
module gpio_periph #(
   parameter int SCAN_DIV  = 1000,
   parameter int DB_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] sw,
   input  logic        disp_en,
   input  logic [31:0] gpio_out,
   output logic [31:0] gpio_in,
   output logic [6:0]  seg,
   output logic [7:0]  an
);

   localparam int CNT_W  = $clog2(DB_CYCLES);
   localparam int PCNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DB_CYCLES - 1);
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SCAN_DIV - 1);

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   logic [17:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [17:0]       sw_stable_q, sw_stable_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic [2:0]        digit_q, digit_d;
   logic [31:0]       snap_q, snap_d;
   logic [7:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;

   // Switch path: synchronize, then accept a level only once it has held for DB_CYCLES cycles.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      sync1_d     = sw;
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      sw_stable_d = sw_stable_q;
      cnt_d       = cnt_q;
      if (sync2_q != prev_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         sw_stable_d = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Display path: prescaler, digit scan, per-frame snapshot and registered drive values.
   always_comb begin
      pcnt_d  = pcnt_q + 1'b1;
      digit_d = digit_q;
      snap_d  = snap_q;
      if (pcnt_q == PCNT_MAX) begin
         pcnt_d  = '0;
         digit_d = digit_q + 3'd1;
         if (digit_q == 3'd7) begin
            snap_d = gpio_out;
         end
      end
      an_d  = disp_en ? ~(8'b1 << digit_q) : 8'hFF;
      seg_d = disp_en ? hex7(snap_q[4*digit_q +: 4]) : 7'h7F;
   end

   // State registers; reset clears all debounce and scan progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         sync1_q     <= '0;
         sync2_q     <= '0;
         prev_q      <= '0;
         sw_stable_q <= '0;
         cnt_q       <= '0;
         pcnt_q      <= '0;
         digit_q     <= '0;
         snap_q      <= '0;
         an_q        <= 8'hFF;
         seg_q       <= 7'h7F;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         sw_stable_q <= sw_stable_d;
         cnt_q       <= cnt_d;
         pcnt_q      <= pcnt_d;
         digit_q     <= digit_d;
         snap_q      <= snap_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign gpio_in = {14'b0, sw_stable_q};
   assign an      = an_q;
   assign seg     = seg_q;

endmodule
